// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
// Sums batches of COUNT adder results into a wide accumulator and presents
// the total, the beat count and an overflow flag under a valid/ready
// handshake. A flush input closes a non-empty batch early.
module adder_result_accumulator #(
    parameter int SUM_WIDTH = 123,
    parameter int COUNT     = 16,
    parameter int ACC_WIDTH = 127,
    parameter int CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [SUM_WIDTH-1:0] in_sum,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Zero bits needed to widen in_sum to the ACC_WIDTH+1 add (keeps the carry).
    localparam int PAD = ACC_WIDTH - SUM_WIDTH + 1;
    // Count value before the final beat of a full batch.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(COUNT - 1);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 out_fire;
    logic [ACC_WIDTH:0]   sum_wide;

    assign accept   = in_valid && (state_q == ACCUM);
    assign out_fire = (state_q == HOLD) && out_ready;
    assign sum_wide = {1'b0, acc_q} + {{PAD{1'b0}}, in_sum};

    // State register: synchronous reset returns to an empty ACCUM batch.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of block ordering.
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, beat counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Next-state logic: close a batch on the COUNT-th beat or a non-empty flush.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            ACCUM: begin
                if (accept && (cnt_q == CNT_LAST)) begin
                    state_d = HOLD;
                end else if (flush && ((cnt_q != '0) || accept)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Datapath next values: add on accept, clear on the output handshake.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = sum_wide[ACC_WIDTH-1:0];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            ovf_d = ovf_q | sum_wide[ACC_WIDTH];
        end else if (out_fire) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Output decode: handshake flags from state only, data straight from registers.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        out_acc   = acc_q;
        out_count = cnt_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Testbench for adder_result_accumulator: directed scenarios plus random
// traffic, checked every cycle against a queue-free running-total model.
module tb_adder_result_accumulator;

    localparam int SW  = 123;
    localparam int CNT = 16;
    localparam int AW  = 127;
    localparam int NW  = 123;
    localparam int CW  = 11;
    localparam int MW  = 140;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [SW-1:0] in_sum;
    logic          flush;
    logic          out_ready;

    logic          in_ready_w,  out_valid_w,  out_ovf_w;
    logic [AW-1:0] out_acc_w;
    logic [CW-1:0] out_count_w;

    logic          in_ready_n,  out_valid_n,  out_ovf_n;
    logic [NW-1:0] out_acc_n;
    logic [CW-1:0] out_count_n;

    adder_result_accumulator #(
        .SUM_WIDTH(SW), .COUNT(CNT), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready_w), .flush(flush), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_acc(out_acc_w), .out_count(out_count_w),
        .out_ovf(out_ovf_w)
    );

    // Narrow accumulator instance, same stimulus, exercises the wrap/overflow path.
    adder_result_accumulator #(
        .SUM_WIDTH(SW), .COUNT(CNT), .ACC_WIDTH(NW), .CNT_WIDTH(CW)
    ) u_dut_narrow (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready_n), .flush(flush), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_acc(out_acc_n), .out_count(out_count_n),
        .out_ovf(out_ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_batches = 0;

    // Reference model: exact (unbounded) batch total, beat count, holding flag.
    logic [MW-1:0] m_total;
    int            m_cnt;
    bit            m_hold;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] rand_sum();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) t = '1;
        return t[SW-1:0];
    endfunction

    task automatic check_outputs();
        check("in_ready",    MW'(in_ready_w),  MW'(!m_hold));
        check("out_valid",   MW'(out_valid_w), MW'(m_hold));
        check("out_acc",     MW'(out_acc_w),   MW'(m_total[AW-1:0]));
        check("out_count",   MW'(out_count_w), MW'(m_cnt));
        check("out_ovf",     MW'(out_ovf_w),   MW'(|m_total[MW-1:AW]));
        check("n_out_valid", MW'(out_valid_n), MW'(m_hold));
        check("n_out_acc",   MW'(out_acc_n),   MW'(m_total[NW-1:0]));
        check("n_out_ovf",   MW'(out_ovf_n),   MW'(|m_total[MW-1:NW]));
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic cycle(input logic v, input logic [SW-1:0] s, input logic f, input logic r);
        @(negedge clk);
        reset = 1'b0; in_valid = v; in_sum = s; flush = f; out_ready = r;
        check_outputs();
        if (!m_hold) begin
            if (v) begin
                m_total = m_total + MW'(s);
                m_cnt++;
            end
            if ((v && m_cnt == CNT) || (f && m_cnt > 0)) m_hold = 1'b1;
        end else if (r) begin
            m_total = '0;
            m_cnt   = 0;
            m_hold  = 1'b0;
            n_batches++;
        end
        @(posedge clk);
    endtask

    // Reset with every other input active, to show reset dominates.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_sum = rand_sum(); flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        m_total = '0; m_cnt = 0; m_hold = 1'b0;
        #1;
        check("rst_in_ready",  MW'(in_ready_w),  MW'(1));
        check("rst_out_valid", MW'(out_valid_w), MW'(0));
        check("rst_out_acc",   MW'(out_acc_w),   MW'(0));
        check("rst_out_count", MW'(out_count_w), MW'(0));
    endtask

    initial begin
        logic [MW-1:0] ones;
        int            start;
        int            cyc;
        ones = MW'({SW{1'b1}});
        reset = 1'b1; in_valid = 1'b0; in_sum = '0; flush = 1'b0; out_ready = 1'b0;
        m_total = '0; m_cnt = 0; m_hold = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Sixteen ones: HOLD after the 16th beat, in_ready low until out_ready.
        for (int i = 0; i < CNT; i++) cycle(1'b1, SW'(1), 1'b0, 1'b0);
        #1;
        check("ones_valid", MW'(out_valid_w), MW'(1));
        check("ones_acc",   MW'(out_acc_w),   MW'(16));
        check("ones_count", MW'(out_count_w), MW'(16));
        for (int i = 0; i < 3; i++) cycle(1'b1, SW'(5), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Sixteen all-ones: no wide overflow, narrow instance wraps and flags.
        for (int i = 0; i < CNT; i++) cycle(1'b1, '1, 1'b0, 1'b0);
        #1;
        check("max_acc",   MW'(out_acc_w), ones << 4);
        check("max_ovf",   MW'(out_ovf_w), MW'(0));
        check("max_n_ovf", MW'(out_ovf_n), MW'(1));
        check("max_n_acc", MW'(out_acc_n), (ones << 4) & ones);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Early flush on the fifth beat, then a flush on an empty batch.
        for (int i = 1; i <= 4; i++) cycle(1'b1, SW'(10 * i), 1'b0, 1'b0);
        cycle(1'b1, SW'(50), 1'b1, 1'b0);
        #1;
        check("flush_acc",   MW'(out_acc_w),   MW'(150));
        check("flush_count", MW'(out_count_w), MW'(5));
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("empty_flush_valid", MW'(out_valid_w), MW'(0));

        // Stall in HOLD with a beat offered, then release it.
        for (int i = 0; i < CNT; i++) cycle(1'b1, rand_sum(), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, SW'(77), 1'b1, 1'b0);
        cycle(1'b1, SW'(77), 1'b0, 1'b1);
        cycle(1'b1, SW'(77), 1'b0, 1'b0);
        #1;
        check("resume_acc",   MW'(out_acc_w),   MW'(77));
        check("resume_count", MW'(out_count_w), MW'(1));
        for (int i = 1; i < CNT; i++) cycle(1'b1, rand_sum(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-batch, then a fresh full batch.
        for (int i = 0; i < 9; i++) cycle(1'b1, rand_sum(), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < CNT; i++) cycle(1'b1, rand_sum(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Random gaps on both handshakes plus occasional flushes over 50 batches.
        start = n_batches;
        cyc   = 0;
        while ((n_batches - start) < 50 && cyc < 20000) begin
            cycle(1'($urandom_range(0, 9) < 7), rand_sum(),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check("rand_batches", MW'(n_batches - start), MW'(50));

        cycle(1'b0, '0, 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
